// File: rtl/multi_debouncer.sv
// ---------------------------------------------------------------------------
// multi_debouncer
//
// N-channel switch/button debouncer. Each channel has its own synchroniser
// chain, a one-clk-delayed copy of the synchronised level (prev), a settle
// counter and a registered debounced level. The debounced level follows the
// input only after the synchronised value has been stable and different
// from the current debounced value for SETTLE tick-qualified clocks. When
// the debounced level changes, a registered one-clk rise or fall pulse is
// produced. Downstream logic therefore needs no separate edge detectors.
//
// Parameters
//   CHANNELS    number of independent channels (>= 1)
//   SYNC_STAGES flops per input synchroniser chain (>= 2)
//   SETTLE      consecutive stable ticks before debounced follows (>= 1)
//   CNT_W       settle counter width, SETTLE <= 2**CNT_W - 1
//   RESET_VAL   reset value of sync flops, prev and debounced
//
// Ports
//   clk        system clock, all logic on posedge
//   reset_     synchronous active-low reset
//   tick       count enable shared by all channels (tie to 1 for every clk)
//   raw        asynchronous raw inputs, one bit per channel
//   debounced  filtered level per channel
//   rise       one-clk pulse when debounced goes 0->1
//   fall       one-clk pulse when debounced goes 1->0
// ---------------------------------------------------------------------------
module multi_debouncer #(
  parameter int   CHANNELS    = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   SETTLE      = 16383,
  parameter int   CNT_W       = 14,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic                tick,
  input  logic [CHANNELS-1:0] raw,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  // -------------------------------------------------------------------------
  // Parameter sanity: refuse to elaborate a configuration that cannot work.
  // -------------------------------------------------------------------------
  if (CHANNELS < 1) begin : g_bad_channels
    $error("multi_debouncer: CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("multi_debouncer: SYNC_STAGES must be >= 2");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("multi_debouncer: SETTLE must be >= 1");
  end
  if (SETTLE > (2 ** CNT_W) - 1) begin : g_bad_cnt_w
    $error("multi_debouncer: CNT_W too narrow for SETTLE");
  end

  // Terminal count: the count that, with a tick, completes the settle window.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

  // Counter action chosen each clock, in priority order.
  typedef enum logic [2:0] {
    ACT_BOUNCE,  // synchronised input moved this clk: restart
    ACT_IDLE,    // input agrees with debounced: nothing pending
    ACT_COMMIT,  // settle window complete: adopt the new level
    ACT_COUNT,   // stable and pending: advance on tick
    ACT_HOLD     // stable and pending, no tick: wait
  } act_e;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   cand;
    logic                   prev_q;
    logic                   deb_q;
    logic                   deb_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    act_e                   act;

    // Oldest stage of the synchroniser is the only value the filter sees.
    assign cand = sync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Action decode. Bounce detection ignores tick so that any movement of
    // the input, even between ticks, restarts the settle window.
    // -----------------------------------------------------------------------
    always_comb begin
      if (cand != prev_q) begin
        act = ACT_BOUNCE;
      end else if (cand == deb_q) begin
        act = ACT_IDLE;
      end else if (tick && (cnt_q == LAST)) begin
        act = ACT_COMMIT;
      end else if (tick) begin
        act = ACT_COUNT;
      end else begin
        act = ACT_HOLD;
      end
    end

    // -----------------------------------------------------------------------
    // Next-state values for counter, debounced level and edge pulses.
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    // -----------------------------------------------------------------------
    always_comb begin
      cnt_d  = cnt_q;
      deb_d  = deb_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      unique case (act)
        ACT_BOUNCE,
        ACT_IDLE: begin
          cnt_d = '0;
        end
        ACT_COMMIT: begin
          cnt_d  = '0;
          deb_d  = cand;
          rise_d = cand;
          fall_d = ~cand;
        end
        ACT_COUNT: begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        default: begin
          // ACT_HOLD: keep the count where it is
        end
      endcase
    end

    // -----------------------------------------------------------------------
    // State registers. Reset abandons any count in progress and suppresses
    // pulses, so a level change caused by reset itself is never reported.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, e.g. prev_q gets the old cand.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
      if (!reset_) begin
        sync_q <= {SYNC_STAGES{RESET_VAL}};
        prev_q <= RESET_VAL;
        deb_q  <= RESET_VAL;
        cnt_q  <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[i]};
        prev_q <= cand;
        deb_q  <= deb_d;
        cnt_q  <= cnt_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign debounced[i] = deb_q;
    assign rise[i]      = rise_q;
    assign fall[i]      = fall_q;

  end : g_ch

endmodule : multi_debouncer

// File: tb/tb_multi_debouncer.sv
// ---------------------------------------------------------------------------
// tb_multi_debouncer
//
// Directed bench for multi_debouncer with CHANNELS=4, SYNC_STAGES=2,
// SETTLE=4, CNT_W=3, RESET_VAL=0. Inputs are driven 1 time unit after a
// rising edge and outputs are sampled at the same point, so "edge k" below
// means the k-th rising edge after the input was changed (counting from 0).
// With tick=1 a new level reaches debounced at edge SYNC_STAGES+SETTLE = 6.
// ---------------------------------------------------------------------------
module tb_multi_debouncer;

  localparam int CH = 4;

  logic          clk;
  logic          reset_;
  logic          tick;
  logic [CH-1:0] raw;
  logic [CH-1:0] debounced;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;

  int n_checks = 0;
  int n_errors = 0;

  multi_debouncer #(
    .CHANNELS   (CH),
    .SYNC_STAGES(2),
    .SETTLE     (4),
    .CNT_W      (3),
    .RESET_VAL  (1'b0)
  ) dut (
    .clk      (clk),
    .reset_   (reset_),
    .tick     (tick),
    .raw      (raw),
    .debounced(debounced),
    .rise     (rise),
    .fall     (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [CH-1:0] got,
                       input logic [CH-1:0] exp);
    n_checks++;
    assert (got === exp)
      else begin
        n_errors++;
        $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
  endtask

  task automatic check_all(input string tag, input logic [CH-1:0] d,
                           input logic [CH-1:0] r, input logic [CH-1:0] f);
    check({tag, ".debounced"}, debounced, d);
    check({tag, ".rise"}, rise, r);
    check({tag, ".fall"}, fall, f);
  endtask

  initial begin
    reset_ = 1'b0;
    tick   = 1'b1;
    raw    = 4'hF;

    // Reset held 3 clks with all inputs high: everything stays low.
    for (int k = 0; k < 3; k++) begin
      step();
      check_all("reset_hold", 4'h0, 4'h0, 4'h0);
    end

    // Release: all four channels settle together at edge 6.
    reset_ = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check_all("reset_release", (k >= 6) ? 4'hF : 4'h0,
                (k == 6) ? 4'hF : 4'h0, 4'h0);
    end

    // Re-reset with inputs low to start from a clean all-zero state. No fall
    // pulse may be reported for the reset-driven drop.
    raw    = 4'h0;
    reset_ = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check_all("reset_clear", 4'h0, 4'h0, 4'h0);
    end
    reset_ = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check_all("idle_zero", 4'h0, 4'h0, 4'h0);

    // Latency: channel 0 goes high, debounced follows at edge 6.
    raw = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      step();
      check_all("latency", (k >= 6) ? 4'b0001 : 4'b0000,
                (k == 6) ? 4'b0001 : 4'b0000, 4'h0);
    end

    // Glitch: channel 1 high for only 3 clks, then low.
    raw = 4'b0011;
    for (int k = 0; k < 3; k++) step();
    raw = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      step();
      check_all("glitch", 4'b0001, 4'h0, 4'h0);
    end

    // Bounce channel 1 every 2 clks for 20 clks (ends low).
    for (int b = 0; b < 20; b++) begin
      raw[1] = ((b % 4) < 2);
      step();
      check_all("bounce", 4'b0001, 4'h0, 4'h0);
    end

    // Final edge and hold: single rise exactly 6 clks later.
    raw = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      step();
      check_all("bounce_settle", (k >= 6) ? 4'b0011 : 4'b0001,
                (k == 6) ? 4'b0010 : 4'b0000, 4'h0);
    end

    // Bring channel 2 high at full rate to set up the gated test.
    raw = 4'b0111;
    for (int k = 0; k < 8; k++) step();
    check_all("gate_setup", 4'b0111, 4'h0, 4'h0);

    // Tick on 1 clk in 4 (edges 0,4,8,...). Channel 2 falls: bounce at
    // edge 2, counts at edges 4, 8, 12, commits at edge 16.
    raw = 4'b0011;
    for (int j = 0; j < 18; j++) begin
      tick = ((j % 4) == 0);
      step();
      check_all("tick_gated", (j >= 16) ? 4'b0011 : 4'b0111, 4'h0,
                (j == 16) ? 4'b0100 : 4'b0000);
    end

    // No tick at all: a pending change never reaches debounced.
    tick = 1'b0;
    raw  = 4'b0111;
    for (int k = 0; k < 40; k++) begin
      step();
      check_all("tick_off", 4'b0011, 4'h0, 4'h0);
    end
    raw = 4'b0011;
    for (int k = 0; k < 4; k++) step();
    tick = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_all("tick_restore", 4'b0011, 4'h0, 4'h0);
    end

    // Channels 0 and 1 fall together.
    raw = 4'h0;
    for (int k = 0; k < 8; k++) begin
      step();
      check_all("simul_fall", (k >= 6) ? 4'h0 : 4'b0011, 4'h0,
                (k == 6) ? 4'b0011 : 4'b0000);
    end

    // Channels 0 and 2 rise together.
    raw = 4'h5;
    for (int k = 0; k < 8; k++) begin
      step();
      check_all("simul_rise", (k >= 6) ? 4'h5 : 4'h0,
                (k == 6) ? 4'h5 : 4'h0, 4'h0);
    end

    // Channel 3 starts counting; stop after edge 4 (count = 2).
    raw = 4'hD;
    for (int k = 0; k < 5; k++) begin
      step();
      check_all("mid_count", 4'h5, 4'h0, 4'h0);
    end

    // Reset mid-count: debounced returns to 0 with no pulse.
    reset_ = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check_all("mid_reset", 4'h0, 4'h0, 4'h0);
    end

    // After release the full latency applies again from scratch.
    reset_ = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check_all("post_reset", (k >= 6) ? 4'hD : 4'h0,
                (k == 6) ? 4'hD : 4'h0, 4'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_multi_debouncer

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- Parametrised N-channel switch/button debouncer: generalises the single-channel debouncer to CHANNELS independent inputs.
- Adds a configurable synchroniser depth, a settle count, a shared count-enable tick and registered one-cycle rise/fall pulses per channel.
- Sits between raw board inputs (buttons, D-pad) and the input-decoding FSMs, so downstream logic needs no separate edge detectors.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- SYNC_STAGES, 2, flops in each input synchroniser chain (>=2).
- SETTLE, 16383, consecutive stable ticks required before debounced follows the input (>=1).
- CNT_W, 14, counter width. Requires SETTLE <= 2^CNT_W - 1; elaboration error otherwise.
- RESET_VAL, 1'b0, reset value of the synchroniser flops, prev and debounced (applies to all channels).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset_  input  1  reset, synchronous, active-low.
- tick  input  1  count enable shared by all channels; tie to 1 to count every clk.
- raw  input  CHANNELS  asynchronous raw inputs.
- debounced  output  CHANNELS  filtered level per channel.
- rise  output  CHANNELS  one-clk pulse when debounced goes 0->1.
- fall  output  CHANNELS  one-clk pulse when debounced goes 1->0.

Behaviour:
- Reset (reset_ low at a posedge):
  - All sync flops, prev and debounced <= RESET_VAL.
  - All counters <= 0; rise and fall <= 0.
  - Reset overrides all other activity and abandons any in-progress count.
- Per channel i, fully independent. cand = output of the last sync stage; prev = cand delayed one clk.
- Counter priority, evaluated each posedge:
  1. cand != prev (bounce): counter <= 0, regardless of tick.
  2. cand == debounced (no pending change): counter <= 0.
  3. tick && counter == SETTLE-1: counter <= 0, debounced <= cand, rise/fall pulse set per direction.
  4. tick: counter <= counter + 1.
  5. Otherwise hold.
- Counter never exceeds SETTLE-1, so no wrap-around is possible.
- rise[i]/fall[i] are registered:
  - High for exactly the one clk in which debounced[i] has just changed; 0 otherwise.
  - rise and fall are never both high on the same channel.
- Latency with tick=1 and raw stable from before posedge 0: debounced and the pulse update at posedge SYNC_STAGES+SETTLE.
- With tick gated, latency scales by the tick period. Bounce detection still runs every clk.
- Any raw change that reaches cand before the count completes restarts the count. A pulse shorter than SETTLE ticks never appears on debounced.
- A raw change that returns to the debounced value mid-count clears the counter (rule 2); no output change.
- Channels changing in the same clk produce simultaneous, independent pulses.

Test Plan:
- Reset: CHANNELS=4, SETTLE=4, SYNC_STAGES=2, RESET_VAL=0, reset_ low 3 clks with raw=4'hF -> debounced=0, rise=fall=0 throughout reset; after release, debounced=4'hF at posedge 6 and rise=4'hF for one clk.
- Latency: tick=1, raw[0] 0->1 before posedge 0 and held -> debounced[0] rises at posedge 6 (2+4), rise[0] high exactly one clk, fall stays 0.
- Glitch rejection: raw[1] high for 3 clks then low -> debounced[1] stays 0 and no pulses. Then bounce 1/0 every 2 clks for 20 clks, then hold 1 -> single rise exactly 6 clks after the final edge.
- Tick gating: tick high 1 clk in 4, raw[2] 1->0 with debounced=1 -> fall[2] pulses only after 4 tick-qualified counts. Drop tick entirely -> debounced holds indefinitely.
- Simultaneous channels and mid-operation reset: raw 4'h0->4'h5 -> rise=4'h5 in one clk. Assert reset_ while channel 3 is at count 2 -> counter cleared, debounced=RESET_VAL, no pulse.
